// File: rtl/board_ctrl_if.sv
// Player-facing bus of the tic-tac-toe board controller: raw buttons in,
// renderer buses and game result out.
interface board_ctrl_if;
  logic        btn_up;
  logic        btn_down;
  logic        btn_left;
  logic        btn_right;
  logic        btn_sel;
  logic        btn_new;
  logic [17:0] Cells;
  logic [8:0]  Color;
  logic        Turn;
  logic        game_over;
  logic [1:0]  winner;

  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_sel, btn_new,
    input  Cells, Color, Turn, game_over, winner
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_sel, btn_new,
    output Cells, Color, Turn, game_over, winner
  );
endinterface

// File: rtl/board_ctrl.sv
// 3x3 game-state controller: button sync, cursor/turn FSM, win/draw detect,
// and mapping of board state onto the renderer's Cells/Color/Turn buses.
module btn_sync (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);
  // [0],[1] = two-flop synchronizer, [2] = delay flop for edge detect
  logic [2:0] sync_q;

  always_ff @(posedge clk or posedge reset)
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[1:0], btn};

  assign pulse = sync_q[1] & ~sync_q[2];
endmodule

module board_ctrl #(
  parameter int BLINK_CYCLES = 25_000_000,
  parameter int CURSOR_RESET = 4
) (
  input  logic         clk,
  input  logic         reset,
  board_ctrl_if.slave  bus
);
  localparam int NUM_BTN   = 6;
  localparam int NUM_CELLS = 9;
  localparam int CW        = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;
  localparam int B_UP = 0, B_DOWN = 1, B_LEFT = 2, B_RIGHT = 3, B_SEL = 4, B_NEW = 5;

  // rows, columns, diagonals as cell masks
  localparam logic [7:0][8:0] LINES = {9'h054, 9'h111, 9'h124, 9'h092,
                                       9'h049, 9'h1C0, 9'h038, 9'h007};

  typedef enum logic [1:0] {PLAY, CHECK, WIN, DRAW} state_t;

  logic [NUM_BTN-1:0]   btn_raw, pulse;
  logic [NUM_CELLS-1:0] occ, own, win_mask, hit;
  logic [3:0]           cursor, moves;
  logic                 turn, blink;
  logic [1:0]           winner;
  logic [CW-1:0]        bcnt;
  state_t               state;
  logic [17:0]          cells;
  logic [8:0]           color;

  assign btn_raw = {bus.btn_new, bus.btn_sel, bus.btn_right,
                    bus.btn_left, bus.btn_down, bus.btn_up};

  btn_sync u_sync [NUM_BTN-1:0] (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_raw),
    .pulse (pulse)
  );

  function automatic logic [3:0] step(input logic [3:0] cur, input int dir);
    logic [1:0] r, c;
    r = 2'(cur / 4'd3);
    c = 2'(cur % 4'd3);
    case (dir)
      B_UP:    r = (r == 2'd0) ? 2'd2 : r - 2'd1;
      B_DOWN:  r = (r == 2'd2) ? 2'd0 : r + 2'd1;
      B_LEFT:  c = (c == 2'd0) ? 2'd2 : c - 2'd1;
      default: c = (c == 2'd2) ? 2'd0 : c + 2'd1;
    endcase
    return 4'(32'(r) * 3 + 32'(c));
  endfunction

  // only the mover's lines can newly complete; earlier checks ruled out the rest
  always_comb begin
    hit = '0;
    for (int i = 0; i < 8; i++)
      if (((occ & LINES[i]) == LINES[i]) && (((own ^ {NUM_CELLS{turn}}) & LINES[i]) == '0))
        hit = hit | LINES[i];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ      <= '0;
      own      <= '0;
      cursor   <= 4'(CURSOR_RESET);
      turn     <= 1'b0;
      moves    <= '0;
      win_mask <= '0;
      winner   <= 2'b00;
      state    <= PLAY;
    end else if (pulse[B_NEW]) begin
      occ      <= '0;
      own      <= '0;
      cursor   <= 4'(CURSOR_RESET);
      turn     <= 1'b0;
      moves    <= '0;
      win_mask <= '0;
      winner   <= 2'b00;
      state    <= PLAY;
    end else begin
      case (state)
        PLAY: begin
          if (pulse[B_SEL]) begin
            if (!occ[cursor]) begin
              occ[cursor] <= 1'b1;
              own[cursor] <= turn;
              moves       <= moves + 4'd1;
              state       <= CHECK;
            end
          end
          else if (pulse[B_UP])    cursor <= step(cursor, B_UP);
          else if (pulse[B_DOWN])  cursor <= step(cursor, B_DOWN);
          else if (pulse[B_LEFT])  cursor <= step(cursor, B_LEFT);
          else if (pulse[B_RIGHT]) cursor <= step(cursor, B_RIGHT);
        end
        CHECK: begin
          if (|hit) begin
            win_mask <= hit;
            winner   <= turn ? 2'b10 : 2'b01;
            state    <= WIN;
          end else if (moves == 4'd9) begin
            winner <= 2'b11;
            state  <= DRAW;
          end else begin
            turn  <= ~turn;
            state <= PLAY;
          end
        end
        default: ;
      endcase
    end
  end

  // free-running blink; deliberately untouched by new game
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcnt  <= '0;
      blink <= 1'b0;
    end else if (bcnt == CW'(BLINK_CYCLES - 1)) begin
      bcnt  <= '0;
      blink <= ~blink;
    end else begin
      bcnt <= bcnt + CW'(1);
    end
  end

  always_comb begin
    cells = '0;
    for (int k = 0; k < NUM_CELLS; k++) begin
      if (occ[k]) begin
        cells[2*k]   = 1'b1;
        cells[2*k+1] = own[k];
      end else if (state == PLAY && cursor == 4'(k)) begin
        cells[2*k]   = blink;
        cells[2*k+1] = turn;
      end
    end
    case (state)
      PLAY:    color = 9'd1 << cursor;
      WIN:     color = blink ? win_mask : 9'h000;
      default: color = 9'h000;
    endcase
  end

  assign bus.Cells     = cells;
  assign bus.Color     = color;
  assign bus.Turn      = turn;
  assign bus.game_over = (state == WIN) || (state == DRAW);
  assign bus.winner    = winner;
endmodule

// File: tb/tb_board_ctrl.sv
// Directed bench for board_ctrl: a game-rules model is compared every cycle,
// plus hand-computed literal checks for each scenario.
module tb_board_ctrl;
  localparam int B = 4;
  localparam int UP = 0, DOWN = 1, LEFT = 2, RIGHT = 3, SEL = 4, NEW = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [5:0] btn = '0;
  int n_chk = 0, n_fail = 0;
  int cur = 4;

  board_ctrl_if bus();
  assign {bus.btn_new, bus.btn_sel, bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up} = btn;

  board_ctrl #(.BLINK_CYCLES(B), .CURSOR_RESET(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ---------------- game-rules model ----------------
  int m_board [9];
  int m_cur, m_turn, m_moves, m_state, m_winner, m_cycles;  // state: 0 play,1 check,2 win,3 draw
  logic [8:0] m_mask;
  logic [5:0] h1, h2, h3;     // button samples from the last three edges
  bit m_ok = 0;
  int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                       '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  task automatic m_clear();
    for (int k = 0; k < 9; k++) m_board[k] = -1;
    m_cur = 4; m_turn = 0; m_moves = 0; m_mask = '0; m_winner = 0; m_state = 0;
  endtask

  task automatic m_init();
    m_clear();
    m_cycles = 0; h1 = '0; h2 = '0; h3 = '0; m_ok = 1;
  endtask

  task automatic m_step();
    logic [5:0] act;
    int r, c;
    act = h2 & ~h3;  // a press first sampled two edges ago acts now
    h3 = h2; h2 = h1; h1 = btn;
    m_cycles++;
    r = m_cur / 3; c = m_cur % 3;
    if (act[NEW]) m_clear();
    else if (m_state == 1) begin
      m_mask = '0;
      for (int l = 0; l < 8; l++)
        if (m_board[lines[l][0]] >= 0 && m_board[lines[l][0]] == m_board[lines[l][1]] &&
            m_board[lines[l][1]] == m_board[lines[l][2]]) begin
          for (int j = 0; j < 3; j++) m_mask[lines[l][j]] = 1'b1;
          m_winner = m_board[lines[l][0]] + 1;
        end
      if (m_mask != '0) m_state = 2;
      else if (m_moves == 9) begin m_state = 3; m_winner = 3; end
      else begin m_turn = 1 - m_turn; m_state = 0; end
    end else if (m_state == 0) begin
      if (act[SEL]) begin
        if (m_board[m_cur] < 0) begin
          m_board[m_cur] = m_turn; m_moves++; m_state = 1;
        end
      end
      else if (act[UP])    m_cur = ((r + 2) % 3) * 3 + c;
      else if (act[DOWN])  m_cur = ((r + 1) % 3) * 3 + c;
      else if (act[LEFT])  m_cur = r * 3 + (c + 2) % 3;
      else if (act[RIGHT]) m_cur = r * 3 + (c + 1) % 3;
    end
  endtask

  always @(posedge clk or posedge reset)
    if (reset) m_init();
    else       m_step();

  function automatic logic [17:0] exp_cells();
    logic [17:0] v;
    logic blink;
    v = '0;
    blink = ((m_cycles / B) % 2) == 1;
    for (int k = 0; k < 9; k++)
      if (m_board[k] >= 0) begin
        v[2*k] = 1'b1; v[2*k+1] = (m_board[k] == 1);
      end else if (m_state == 0 && k == m_cur) begin
        v[2*k] = blink; v[2*k+1] = (m_turn == 1);
      end
    return v;
  endfunction

  function automatic logic [8:0] exp_color();
    logic blink;
    blink = ((m_cycles / B) % 2) == 1;
    if (m_state == 0) return 9'(1 << m_cur);
    if (m_state == 2) return blink ? m_mask : 9'h000;
    return 9'h000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (m_ok) begin
      chk("cells",     32'(bus.Cells),     32'(exp_cells()));
      chk("color",     32'(bus.Color),     32'(exp_color()));
      chk("turn",      32'(bus.Turn),      32'(m_turn));
      chk("game_over", 32'(bus.game_over), 32'(m_state >= 2));
      chk("winner",    32'(bus.winner),    32'(m_winner));
    end

  // ---------------- stimulus ----------------
  task automatic press(input int b, input int hold = 2);
    @(negedge clk); btn[b] = 1'b1;
    repeat (hold) @(negedge clk);
    btn[b] = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic goto_sel(input int tgt);
    int dr, dc;
    dr = (tgt / 3 - cur / 3 + 3) % 3;
    dc = (tgt % 3 - cur % 3 + 3) % 3;
    repeat (dr) press(DOWN);
    repeat (dc) press(RIGHT);
    cur = tgt;
    press(SEL);
  endtask

  task automatic new_game();
    press(NEW); cur = 4;
  endtask

  task automatic play_row0_win();
    new_game();
    goto_sel(0); goto_sel(3); goto_sel(1); goto_sel(4); goto_sel(2);
  endtask

  initial begin
    logic [17:0] snap;
    int n007, n000;

    // 1: reset values, blink after B cycles, async reset mid-game
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_cells", 32'(bus.Cells), 32'h0);
    chk("rst_color", 32'(bus.Color), 32'h010);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_blink_cells", 32'(bus.Cells), 32'h0);
    @(negedge clk);
    chk("blink_cells", 32'(bus.Cells), 32'h00100);
    press(SEL); press(RIGHT);
    @(posedge clk); #2 reset = 1'b1;
    #1;
    chk("async_cells",  32'(bus.Cells),     32'h0);
    chk("async_color",  32'(bus.Color),     32'h010);
    chk("async_turn",   32'(bus.Turn),      32'h0);
    chk("async_winner", 32'(bus.winner),    32'h0);
    chk("async_over",   32'(bus.game_over), 32'h0);
    @(negedge clk); reset = 1'b0; cur = 4;

    // 2: cursor moves with wrap, held button acts once
    press(RIGHT); chk("mv_right",  32'(bus.Color), 32'h020);
    press(RIGHT); chk("mv_wrap",   32'(bus.Color), 32'h008);
    press(UP);    chk("mv_up",     32'(bus.Color), 32'h001);
    press(LEFT);  chk("mv_left",   32'(bus.Color), 32'h004);
    press(RIGHT, 50); chk("mv_held", 32'(bus.Color), 32'h001);

    // 3: place at 4, then reselect occupied cell
    new_game();
    press(SEL);
    chk("sel_cell4", 32'(bus.Cells[9:8]), 32'h1);
    chk("sel_turn",  32'(bus.Turn),       32'h1);
    snap = bus.Cells;
    press(SEL);
    chk("resel_cells", 32'(bus.Cells), 32'(snap));
    chk("resel_turn",  32'(bus.Turn),  32'h1);

    // 4: player 0 wins on top row
    play_row0_win();
    chk("win_winner", 32'(bus.winner),    32'h1);
    chk("win_over",   32'(bus.game_over), 32'h1);
    chk("win_turn",   32'(bus.Turn),      32'h0);
    chk("win_cells",  32'(bus.Cells),     32'h003D5);
    n007 = 0; n000 = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.Color == 9'h007) n007++;
      if (bus.Color == 9'h000) n000++;
    end
    chk("win_flash_on",  32'(n007), 32'd4);
    chk("win_flash_off", 32'(n000), 32'd4);
    press(RIGHT); press(SEL);
    chk("win_frozen_cells",  32'(bus.Cells),  32'h003D5);
    chk("win_frozen_winner", 32'(bus.winner), 32'h1);

    // 5: draw
    new_game();
    goto_sel(0); goto_sel(1); goto_sel(2); goto_sel(4); goto_sel(3);
    goto_sel(5); goto_sel(7); goto_sel(6); goto_sel(8);
    chk("draw_winner", 32'(bus.winner),    32'h3);
    chk("draw_over",   32'(bus.game_over), 32'h1);
    chk("draw_color",  32'(bus.Color),     32'h0);
    chk("draw_cells",  32'(bus.Cells),     32'h17F5D);

    // 6: new beats sel in the same cycle; new during WIN
    new_game();
    goto_sel(0);
    chk("pre_new_turn", 32'(bus.Turn), 32'h1);
    @(negedge clk); btn[SEL] = 1'b1; btn[NEW] = 1'b1;
    repeat (2) @(negedge clk);
    btn = '0;
    repeat (4) @(negedge clk);
    cur = 4;
    chk("new_sel_turn",  32'(bus.Turn),  32'h0);
    chk("new_sel_color", 32'(bus.Color), 32'h010);
    chk("new_sel_cells", 32'(bus.Cells & 18'h3FCFF), 32'h0);
    chk("new_sel_ghost", 32'(bus.Cells[9]), 32'h0);
    play_row0_win();
    chk("win2_over", 32'(bus.game_over), 32'h1);
    new_game();
    chk("new_win_winner", 32'(bus.winner),    32'h0);
    chk("new_win_over",   32'(bus.game_over), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
